// File: rtl/pmt_pkg.sv
// rtl/pmt_pkg.sv - shared state encoding and constants for the PMT time-bin sequencer
package pmt_pkg;

    localparam int CNT_W_DEF   = 8;
    localparam int BIN_W_DEF   = 32;
    localparam int NBIN_W_DEF  = 16;

    // Shortest usable bin: a 1-cycle bin would leave no cycle between clears
    localparam int MIN_BIN_LEN = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/pmt_bin_timer.sv
// rtl/pmt_bin_timer.sv - bin-length up counter with terminal-count pulse
module pmt_bin_timer
    import pmt_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             en,
    input  logic [BIN_W-1:0] len,
    output logic             tc
);

    logic [BIN_W-1:0] cnt_q;
    logic [BIN_W-1:0] cnt_d;

    // Count 0..len-1 while enabled; tc marks the last cycle of the bin
    always_comb begin
        tc    = en && (cnt_q == (len - BIN_W'(1)));
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : (cnt_q + BIN_W'(1));
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pmt_timebin_sequencer.sv
// rtl/pmt_timebin_sequencer.sv - run-controlled PMT time-bin scheduler with tagged sample stream
module pmt_timebin_sequencer
    import pmt_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int BIN_W  = BIN_W_DEF,
    parameter int NBIN_W = NBIN_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BIN_W-1:0]        cfg_bin_len,
    input  logic [NBIN_W-1:0]       cfg_num_bins,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CNT_W-1:0]        pmt_count,
    output logic                    cnt_clear,
    output logic [NBIN_W+CNT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic                    LED
);

    state_e                  state_q, state_d;
    logic [BIN_W-1:0]        bin_len_q, bin_len_d;
    logic [NBIN_W-1:0]       num_bins_q, num_bins_d;
    logic [NBIN_W-1:0]       bin_idx_q, bin_idx_d;
    logic                    cnt_clear_q, cnt_clear_d;
    logic [NBIN_W+CNT_W-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overflow_q, overflow_d;
    logic                    led_q, led_d;
    logic                    timer_clear;
    logic                    timer_en;
    logic                    bin_tc;

    pmt_bin_timer #(
        .BIN_W (BIN_W)
    ) u_timer (
        .clk    (clk),
        .resetn (reset),
        .clear  (timer_clear),
        .en     (timer_en),
        .len    (bin_len_q),
        .tc     (bin_tc)
    );

    // Run FSM, bin bookkeeping and single-stage output register
    always_comb begin
        state_d     = state_q;
        bin_len_d   = bin_len_q;
        num_bins_d  = num_bins_q;
        bin_idx_d   = bin_idx_q;
        cnt_clear_d = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        led_d       = led_q;
        timer_clear = 1'b0;
        timer_en    = (state_q == ST_RUN);

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    bin_len_d   = (cfg_bin_len < BIN_W'(MIN_BIN_LEN)) ? BIN_W'(MIN_BIN_LEN) : cfg_bin_len;
                    num_bins_d  = cfg_num_bins;
                    overflow_d  = 1'b0;
                    bin_idx_d   = '0;
                    timer_clear = 1'b1;
                    if (cfg_num_bins == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_RUN;
                        cnt_clear_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else if (bin_tc) begin
                    cnt_clear_d = 1'b1;
                    led_d       = ~led_q;
                    bin_idx_d   = bin_idx_q + NBIN_W'(1);
                    // A sample still waiting on a stalled sink wins; the new one is lost
                    if (!out_valid_q || out_ready) begin
                        out_data_d  = {bin_idx_q, pmt_count};
                        out_valid_d = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if (bin_idx_q == (num_bins_q - NBIN_W'(1))) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else if (!out_valid_q || out_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bin_len_q   <= BIN_W'(MIN_BIN_LEN);
            num_bins_q  <= '0;
            bin_idx_q   <= '0;
            cnt_clear_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_len_q   <= bin_len_d;
            num_bins_q  <= num_bins_d;
            bin_idx_q   <= bin_idx_d;
            cnt_clear_q <= cnt_clear_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            led_q       <= led_d;
        end
    end

    assign cnt_clear = cnt_clear_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign LED       = led_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);

endmodule
